logic_pipe: RTL and testbench
=============================

LOGIC_PIPE -- requirements
Module: logic_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (1..64).
REQ-002 Parameter CNT_W, default 16, width of the completed-transfer counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream presents op/a/b this cycle.
REQ-006 in_ready  output  1  block accepts op/a/b this cycle.
REQ-007 op  input  3  operation select, sampled on accept.
REQ-008 a  input  WIDTH  operand A, sampled on accept.
REQ-009 b  input  WIDTH  operand B, sampled on accept; ignored by unary ops.
REQ-010 out_valid  output  1  f/zero hold a valid result.
REQ-011 out_ready  input  1  downstream takes result this cycle.
REQ-012 f  output  WIDTH  result.
REQ-013 zero  output  1  high when f is all zeros (qualified by out_valid).
REQ-014 done_cnt  output  CNT_W  count of completed output transfers.

Function
REQ-015 Op encoding SHALL be: 000 ~a, 001 a&b, 010 a|b, 011 a^b, 100 ~(a&b), 101 ~(a|b), 110 ~(a^b), 111 a (pass).
REQ-016 Operations SHALL be bitwise over all WIDTH bits; no carries, no width change.
REQ-017 Accept SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-018 Datapath SHALL be two register stages: S1 stores computed result and zero flag, S2 drives f/zero/out_valid.
REQ-019 Latency SHALL be exactly 2 cycles from accept edge to out_valid when out_ready held high.
REQ-020 Each stage SHALL load when empty or when its downstream consumes it in the same cycle.
REQ-021 in_ready SHALL be high iff S1 is empty or S1 advances into S2 this cycle (combinational from out_ready).
REQ-022 With out_ready held high, throughput SHALL be one accept per cycle, no bubbles.
REQ-023 With out_ready low, S2 then S1 SHALL fill; in_ready SHALL drop after 2 un-drained accepts; no data lost or duplicated.
REQ-024 While out_valid && !out_ready, f, zero and out_valid SHALL hold stable.
REQ-025 Simultaneous accept and output transfer SHALL both complete in the same cycle.
REQ-026 Results SHALL emerge in accept order.
REQ-027 done_cnt SHALL increment by 1 per output transfer and saturate at all-ones (no wrap).
REQ-028 in_valid with in_ready low SHALL have no effect; upstream holds inputs.
REQ-029 op values are all defined; no illegal-op state exists.

Reset
REQ-030 rst high SHALL asynchronously clear both stage valid bits, f, zero, done_cnt to 0.
REQ-031 During reset in_ready SHALL be 1 after the clear settles, but no accept occurs while rst is high.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight results; first out_valid after release appears 2 cycles after the first post-reset accept.

Verification (WIDTH=8)
REQ-033 Truth table: for each op 000..111 with a=8'hC5, b=8'h3A, out_ready=1 -> f = 3A, 00, FF, FF, FF, 00, 00, C5 respectively, 2 cycles after accept; zero=1 only for the 00 results.
REQ-034 Streaming: 16 back-to-back accepts (op=000, a=0..15), out_ready=1 -> 16 consecutive out_valid cycles, f=FF..F0 in order, done_cnt=16.
REQ-035 Backpressure: out_ready=0, send 3 items -> in_ready low after 2nd accept, 3rd held; raise out_ready -> 3 results in order, f stable while stalled.
REQ-036 Reset mid-stream: 2 items in flight, pulse rst between clock edges -> out_valid=0, done_cnt=0 immediately; no stale result afterwards.
REQ-037 Saturation: CNT_W=2, 5 transfers -> done_cnt sequence 1,2,3,3,3.
REQ-038 Random: random op/a/b/in_valid/out_ready for 10k cycles -> scoreboard matches reference model, no loss, reorder, or duplication.

Source files
------------

// File: rtl/logic_pipe_if.sv
// Handshake bundle for logic_pipe: an upstream operand channel (valid/ready
// with op/a/b) and a downstream result channel (valid/ready with f/zero).
// The pipe itself connects through the slave view. The producer/consumer
// side (a testbench or a surrounding block) uses the master view.
interface logic_pipe_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             zero;

  modport slave (
    input  in_valid,
    input  op,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output f,
    output zero
  );

  modport master (
    output in_valid,
    output op,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  f,
    input  zero
  );

endinterface

// File: rtl/logic_pipe.sv
// logic_pipe: a two-stage, fully back-pressured bitwise logic unit.
// S1 captures the computed result and its zero flag when an operand set is
// accepted. S2 is the output register that drives f/zero/out_valid.
// The pipe holds at most two results. in_ready looks ahead through
// out_ready, so it still accepts at full rate while the output drains.
module logic_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  logic_pipe_if.slave      bus,
  output logic [CNT_W-1:0] done_cnt
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_f;
  logic             s1_zero;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_f;
  logic             s2_zero;

  logic [WIDTH-1:0] alu_f;
  logic             alu_zero;

  logic             s2_load;
  logic             accept;
  logic             xfer;

  // S2 can take new data when it is empty or is being drained this cycle.
  // S1 can take new data when it is empty or is moving into S2.
  assign xfer         = s2_valid && bus.out_ready;
  assign s2_load      = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_load;
  assign accept       = bus.in_valid && bus.in_ready;

  // Bitwise operation select. Every op code is defined, so no error path exists.
  always_comb begin
    alu_f = '0;
    case (bus.op)
      3'b000:  alu_f = ~bus.a;
      3'b001:  alu_f = bus.a & bus.b;
      3'b010:  alu_f = bus.a | bus.b;
      3'b011:  alu_f = bus.a ^ bus.b;
      3'b100:  alu_f = ~(bus.a & bus.b);
      3'b101:  alu_f = ~(bus.a | bus.b);
      3'b110:  alu_f = ~(bus.a ^ bus.b);
      default: alu_f = bus.a;
    endcase
    alu_zero = (alu_f == '0);
  end

  // S1 occupancy. Whenever in_ready is high, S1 is either empty or moving
  // forward, so its next occupancy is exactly whether a new item arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
    end
  end

  // S1 payload. It loads only on accept, so the payload is held while S1 waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_f    <= '0;
      s1_zero <= 1'b0;
    end else if (accept) begin
      s1_f    <= alu_f;
      s1_zero <= alu_zero;
    end
  end

  // S2 output register. It is frozen while a result is stalled downstream.
  // The payload only changes when real data arrives from S1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_f     <= '0;
      s2_zero  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_f    <= s1_f;
        s2_zero <= s1_zero;
      end
    end
  end

  // Completed-transfer counter. It sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (xfer && (done_cnt != {CNT_W{1'b1}})) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.f         = s2_f;
  assign bus.zero      = s2_zero;

endmodule

// File: tb/tb_logic_pipe.sv
// Self-checking bench for logic_pipe (WIDTH=8). A main instance is checked
// cycle by cycle against a queue-based reference model. A second instance
// with CNT_W=2 exercises counter saturation.
module tb_logic_pipe;

  logic clk;
  logic rst;
  logic [15:0] done_cnt;
  logic [1:0]  sat_cnt;

  logic_pipe_if #(.WIDTH(8)) bus ();
  logic_pipe_if #(.WIDTH(8)) sbus ();

  logic_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .done_cnt (done_cnt)
  );

  logic_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .bus      (sbus),
    .done_cnt (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] f;
    logic       zero;
    int         acc_cyc;
  } item_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] f;
    logic       zero;
  } vec_t;

  item_t      q[$];
  logic [7:0] got[$];
  int         got_cyc[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         exp_cnt = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_f = '0;
  logic       prev_zero = 1'b0;
  logic       s_ov, s_zero, s_rdy, last_acc, last_xfer;
  logic [7:0] s_f;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference behaviour, written straight from the op table.
  function automatic logic [7:0] ref_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  task automatic drive(input logic iv, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic ordy);
    bus.in_valid  = iv;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = ordy;
  endtask

  // Call at a falling edge after driving inputs. The task checks the cycle
  // against the model, updates the model with what the next rising edge
  // will do, and returns at the following falling edge.
  task automatic tick();
    item_t it;
    logic  exp_ov;
    #1;
    s_ov   = bus.out_valid;
    s_f    = bus.f;
    s_zero = bus.zero;
    s_rdy  = bus.in_ready;
    chk("in_ready", s_rdy, (q.size() < 2) || bus.out_ready);
    exp_ov = 1'b0;
    if (q.size() > 0) exp_ov = (cyc - q[0].acc_cyc) >= 2;
    chk("out_valid", s_ov, exp_ov);
    if (s_ov && exp_ov) begin
      chk("f", s_f, q[0].f);
      chk("zero", s_zero, q[0].zero);
    end
    if (stall_prev) begin
      chk("stall_f", s_f, prev_f);
      chk("stall_zero", s_zero, prev_zero);
    end
    chk("done_cnt", done_cnt, exp_cnt);
    last_xfer = s_ov && bus.out_ready;
    last_acc  = bus.in_valid && s_rdy;
    if (last_xfer) begin
      got.push_back(s_f);
      got_cyc.push_back(cyc);
      if (q.size() > 0) void'(q.pop_front());
      exp_cnt++;
    end
    if (last_acc) begin
      it.f       = ref_fn(bus.op, bus.a, bus.b);
      it.zero    = (it.f == 8'h00);
      it.acc_cyc = cyc;
      q.push_back(it);
    end
    stall_prev = s_ov && !bus.out_ready;
    prev_f     = s_f;
    prev_zero  = s_zero;
    @(negedge clk);
    cyc++;
  endtask

  // Reset pulse placed between clock edges, with an immediate check of the cleared state.
  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_f", bus.f, 0);
    #1 rst = 1'b0;
    q.delete();
    exp_cnt    = 0;
    stall_prev = 1'b0;
    @(negedge clk);
    cyc++;
  endtask

  vec_t tv[8];
  int   sat_exp[10];
  int   sat_smp[10];

  initial begin
    tv[0] = '{3'b000, 8'hC5, 8'h3A, 8'h3A, 1'b0};
    tv[1] = '{3'b001, 8'hC5, 8'h3A, 8'h00, 1'b1};
    tv[2] = '{3'b010, 8'hC5, 8'h3A, 8'hFF, 1'b0};
    tv[3] = '{3'b011, 8'hC5, 8'h3A, 8'hFF, 1'b0};
    tv[4] = '{3'b100, 8'hC5, 8'h3A, 8'hFF, 1'b0};
    tv[5] = '{3'b101, 8'hC5, 8'h3A, 8'h00, 1'b1};
    tv[6] = '{3'b110, 8'hC5, 8'h3A, 8'h00, 1'b1};
    tv[7] = '{3'b111, 8'hC5, 8'h3A, 8'hC5, 1'b0};
    sat_exp = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 3};

    // Power-on reset
    rst = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
    sbus.in_valid  = 1'b0;
    sbus.op        = 3'd7;
    sbus.a         = 8'h00;
    sbus.b         = 8'h00;
    sbus.out_ready = 1'b1;
    #3;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_f", bus.f, 0);
    chk("reset_zero", bus.zero, 0);
    chk("reset_done_cnt", done_cnt, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_sat_cnt", sat_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Streaming: 16 back-to-back accepts
    got.delete();
    got_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'b000, 8'(i), 8'h00, 1'b1);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
      tick();
    end
    chk("stream_count", got.size(), 16);
    if (got.size() == 16) begin
      for (int i = 0; i < 16; i++) chk("stream_f", got[i], 8'hFF - 8'(i));
      chk("stream_no_bubble", got_cyc[15] - got_cyc[0], 15);
    end
    chk("stream_done_cnt", done_cnt, 16);

    // Truth table, one item at a time
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tv[i].op, tv[i].a, tv[i].b, 1'b1);
      tick();
      drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      tick();
      chk("tt_not_early", s_ov, 0);
      tick();
      chk("tt_out_valid", s_ov, 1);
      chk("tt_f", s_f, tv[i].f);
      chk("tt_zero", s_zero, tv[i].zero);
    end

    // Backpressure: three items against a stalled output
    got.delete();
    drive(1'b1, 3'b001, 8'hF0, 8'h3C, 1'b0);
    tick();
    chk("bp_acc1", last_acc, 1);
    drive(1'b1, 3'b011, 8'hAA, 8'hFF, 1'b0);
    tick();
    chk("bp_acc2", last_acc, 1);
    drive(1'b1, 3'b111, 8'h81, 8'h00, 1'b0);
    tick();
    chk("bp_rdy_low", s_rdy, 0);
    chk("bp_held", last_acc, 0);
    tick();
    chk("bp_rdy_low2", s_rdy, 0);
    chk("bp_stall_f", s_f, 8'h30);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'b111, 8'h81, 8'h00, 1'b1);
      tick();
      if (last_acc) break;
    end
    chk("bp_acc3", last_acc, 1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      tick();
    end
    chk("bp_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("bp_r0", got[0], 8'h30);
      chk("bp_r1", got[1], 8'h55);
      chk("bp_r2", got[2], 8'h81);
    end

    // Reset while two items are in flight
    drive(1'b1, 3'b000, 8'h12, 8'h00, 1'b0);
    tick();
    drive(1'b1, 3'b000, 8'h34, 8'h00, 1'b0);
    tick();
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    reset_pulse();
    got.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      tick();
    end
    chk("rst_no_stale", got.size(), 0);
    drive(1'b1, 3'b101, 8'h0F, 8'hF0, 1'b1);
    tick();
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
    tick();
    chk("rst_lat_early", s_ov, 0);
    tick();
    chk("rst_lat_ov", s_ov, 1);
    chk("rst_lat_f", s_f, 8'h00);
    chk("rst_lat_zero", s_zero, 1);
    tick();

    // Counter saturation on the CNT_W=2 instance
    for (int i = 0; i < 10; i++) begin
      sbus.in_valid = (i < 5);
      sbus.a        = 8'(i);
      drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      #1;
      sat_smp[i] = int'(sat_cnt);
      tick();
    end
    sbus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) chk("sat_cnt", sat_smp[i], sat_exp[i]);

    // Random traffic; a refused operand set is held until it is taken
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
    last_acc = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!(bus.in_valid && !last_acc)) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.op       = 3'($urandom_range(0, 7));
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      tick();
    end
    chk("drain_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
